// File: rtl/mem_access_ctrl.sv
// Byte/half/word load-store front end for a word-addressed data memory (read-modify-write for sub-word stores).
// Latency request->resp_valid: load 2, word store 2, sub-word store 3, misaligned/rejected 1 cycle.
// Backpressure: stall is held while a request is being accepted or memory is busy; req_* must stay stable meanwhile.
// Optional feature macro: MEM_BOUNDS_CHECK_EN (reject word indices >= DM_WORDS instead of wrapping).
module mem_access_ctrl #(
  parameter int DM_WORDS = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        misalign_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_MemWrite,
  output logic        dm_MemRead,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [2:0] {IDLE, RD, WR, RESP, ERR} state_t;

  state_t      state;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_lo;
  logic [15:0] lat_wdata;
  logic [31:0] lat_widx;

  logic        req_misaligned;
  logic        req_reject;
  logic [31:0] req_widx;

  // Pick the addressed byte or half out of a memory word and extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   load_extract = uns ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_extract = w;
    endcase
  endfunction

  // Replace the target byte or half of the old word with the store data.
  function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lo, input logic [15:0] d);
    logic [31:0] m;
    m = w;
    if (sz == 2'b00) m[{lo, 3'b000} +: 8] = d[7:0];
    else             m[{lo[1], 4'b0000} +: 16] = d;
    return m;
  endfunction

  // Decode alignment, range and word index of the presented request.
  always_comb begin
    req_misaligned = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    req_widx = {2'b00, req_addr[31:2]} % 32'(DM_WORDS);
`ifdef MEM_BOUNDS_CHECK_EN
    req_reject = req_misaligned || ({2'b00, req_addr[31:2]} >= 32'(DM_WORDS));
`else
    req_reject = req_misaligned;
`endif
  end

  // The pipeline must hold while a request is being taken or memory is still in use.
  assign stall = (state == IDLE && req_valid) || state == RD || state == WR;

  // Access sequencer; every output is set on the edge that enters the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'h0;
      misalign_err <= 1'b0;
      dm_addr      <= 32'h0;
      dm_wdata     <= 32'h0;
      dm_MemWrite  <= 1'b0;
      dm_MemRead   <= 1'b0;
      lat_write    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
      lat_lo       <= 2'b00;
      lat_wdata    <= 16'h0;
      lat_widx     <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_lo       <= req_addr[1:0];
            lat_wdata    <= req_wdata[15:0];
            lat_widx     <= req_widx;
            if (req_reject) begin
              state        <= ERR;
              resp_valid   <= 1'b1;
              misalign_err <= 1'b1;
              resp_rdata   <= 32'h0;
            end else if (req_write && req_size == 2'b10) begin
              state       <= WR;
              dm_MemWrite <= 1'b1;
              dm_wdata    <= req_wdata;
              dm_addr     <= req_widx;
            end else begin
              state      <= RD;
              dm_MemRead <= 1'b1;
              dm_addr    <= req_widx;
            end
          end
        end
        RD: begin
          dm_MemRead <= 1'b0;
          if (lat_write) begin
            state       <= WR;
            dm_MemWrite <= 1'b1;
            dm_wdata    <= store_merge(dm_rdata, lat_size, lat_lo, lat_wdata);
          end else begin
            state      <= RESP;
            dm_addr    <= 32'h0;
            resp_valid <= 1'b1;
            resp_rdata <= load_extract(dm_rdata, lat_size, lat_lo, lat_unsigned);
          end
        end
        WR: begin
          state       <= RESP;
          dm_MemWrite <= 1'b0;
          dm_addr     <= 32'h0;
          dm_wdata    <= 32'h0;
          resp_valid  <= 1'b1;
          resp_rdata  <= 32'h0;
        end
        default: begin
          // RESP and ERR: req_* still describes the finishing access, so nothing is latched.
          state        <= IDLE;
          resp_valid   <= 1'b0;
          misalign_err <= 1'b0;
          resp_rdata   <= 32'h0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: data memory model, behavioural reference, directed plus random requests.
// Honours MEM_BOUNDS_CHECK_EN the same way as the design.
module tb_mem_access_ctrl;

  localparam int WORDS = 128;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        stall, resp_valid, misalign_err, dm_MemWrite, dm_MemRead;
  logic [31:0] resp_rdata, dm_addr, dm_wdata, dm_rdata;

  logic [31:0] tb_mem [WORDS];
  logic [31:0] ref_mem [WORDS];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.DM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .misalign_err(misalign_err), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_MemWrite(dm_MemWrite), .dm_MemRead(dm_MemRead), .dm_rdata(dm_rdata)
  );

  // Word-addressed data memory: combinational read, clocked write.
  assign dm_rdata = tb_mem[dm_addr[6:0]];
  always @(posedge clk) if (dm_MemWrite) tb_mem[dm_addr[6:0]] <= dm_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request (called at a negedge) and check every cycle up to the response.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] got_rd, output logic got_err, output logic [31:0] got_wd);
    logic        err, rd_phase;
    int          k, lat, widx;
    logic [31:0] old, nw, exp_rd, mask, lane;
    err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0);
`ifdef MEM_BOUNDS_CHECK_EN
    if ((a >> 2) >= WORDS) err = 1'b1;
`endif
    widx = int'((a >> 2) % WORDS);
    k    = int'(a[1:0]);
    old  = ref_mem[widx];
    // Reference arithmetic: shifts and masks on whole words.
    if (sz == 2'd0)      mask = 32'hFF << (8 * k);
    else if (sz == 2'd1) mask = 32'hFFFF << (8 * (k & 2));
    else                 mask = 32'hFFFF_FFFF;
    nw   = (old & ~mask) | ((wd << (8 * (sz == 2'd1 ? (k & 2) : (sz == 2'd0 ? k : 0)))) & mask);
    lane = (old & mask) >> (8 * (sz == 2'd1 ? (k & 2) : (sz == 2'd0 ? k : 0)));
    if (w || err)        exp_rd = 32'h0;
    else if (sz == 2'd0) exp_rd = u ? lane : 32'($signed(lane[7:0]));
    else if (sz == 2'd1) exp_rd = u ? lane : 32'($signed(lane[15:0]));
    else                 exp_rd = lane;
    lat = err ? 1 : ((w && sz != 2'd2) ? 3 : 2);
    rd_phase = !err && (!w || sz != 2'd2);
    got_rd = 32'h0; got_err = 1'b0; got_wd = 32'h0;
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
    req_addr = a; req_wdata = wd;
    for (int i = 0; i <= lat; i++) begin
      #1;
      chk("stall", {31'h0, stall}, {31'h0, i < lat});
      chk("dm_MemRead", {31'h0, dm_MemRead}, {31'h0, rd_phase && i == 1});
      chk("dm_MemWrite", {31'h0, dm_MemWrite}, {31'h0, !err && w && i == lat - 1});
      chk("dm_addr", dm_addr,
          ((rd_phase && i == 1) || (!err && w && i == lat - 1)) ? widx : 32'h0);
      if (!err && w && i == lat - 1) begin
        chk("dm_wdata", dm_wdata, nw);
        got_wd = dm_wdata;
      end
      chk("resp_valid", {31'h0, resp_valid}, {31'h0, i == lat});
      chk("misalign_err", {31'h0, misalign_err}, {31'h0, err && i == lat});
      if (i == lat) begin
        chk("resp_rdata", resp_rdata, exp_rd);
        got_rd = resp_rdata;
        got_err = misalign_err;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    if (w && !err) ref_mem[widx] = nw;
  endtask

  // Idle cycles with random junk on req_*; everything must stay quiet.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      #1;
      chk("idle_quiet", {27'h0, stall, resp_valid, dm_MemRead, dm_MemWrite, misalign_err}, 32'h0);
      chk("idle_dm_addr", dm_addr, 32'h0);
      @(negedge clk);
    end
  endtask

  logic [31:0] rd, wdv;
  logic        er;

  initial begin
    for (int i = 0; i < WORDS; i++) begin
      tb_mem[i] = $urandom;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[3] = 32'h8899AABB; ref_mem[3] = 32'h8899AABB;
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_flags", {27'h0, stall, resp_valid, dm_MemRead, dm_MemWrite, misalign_err}, 32'h0);
    chk("reset_outs", resp_rdata | dm_addr | dm_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(2);

    // Directed cases with hand-computed results.
    do_req(1'b0, 2'd0, 1'b0, 32'h0D, 32'h0, rd, er, wdv);
    chk("lb_0x0D", rd, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b1, 32'h0D, 32'h0, rd, er, wdv);
    chk("lbu_0x0D", rd, 32'h000000AA);
    do_req(1'b0, 2'd1, 1'b0, 32'h0E, 32'h0, rd, er, wdv);
    chk("lh_0x0E", rd, 32'hFFFF8899);
    do_req(1'b1, 2'd1, 1'b0, 32'h0E, 32'hCAFE1234, rd, er, wdv);
    chk("sh_wdata", wdv, 32'h1234AABB);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, er, wdv);
    chk("sw_wdata", wdv, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, wdv);
    chk("lw_0x10", rd, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'h0, rd, er, wdv);
    chk("lw_0x06_err", {31'h0, er}, 32'h1);
    do_req(1'b1, 2'd3, 1'b0, 32'h08, 32'h0, rd, er, wdv);
    chk("size11_err", {31'h0, er}, 32'h1);
    idle_cycles(1);

    // Reset while a byte store sits in its write cycle.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h21; req_wdata = 32'h55;
    repeat (2) @(negedge clk);
    #1;
    chk("sb_in_wr", {31'h0, dm_MemWrite}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_memwrite_drop", {31'h0, dm_MemWrite}, 32'h0);
    chk("rst_no_resp", {31'h0, resp_valid}, 32'h0);
    req_valid = 1'b0;
    #1;
    chk("rst_stall_low", {31'h0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);

    // Past the end of memory: rejected with bounds checking, wrapped onto word 0 without.
    do_req(1'b1, 2'd2, 1'b0, 32'h200, 32'h0BADF00D, rd, er, wdv);
`ifdef MEM_BOUNDS_CHECK_EN
    chk("sw_0x200_err", {31'h0, er}, 32'h1);
`else
    chk("sw_0x200_err", {31'h0, er}, 32'h0);
    chk("sw_0x200_mem0", tb_mem[0], 32'h0BADF00D);
`endif

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 1023)) : 32'($urandom_range(0, 511));
      do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd, er, wdv);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 2)));
    end

    idle_cycles(1);
    for (int i = 0; i < WORDS; i++) chk("final_mem", tb_mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
